// File: rtl/y_mc_ctrl.sv
// Multi-cycle sequencer for the yIF/yID/yEX/yDM/yWB/yPC datapath: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, drives the shared memory handshake and counts retirements.
module y_mc_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        run,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        addr_sel,
   output logic        ir_load,
   output logic        pc_write,
   output logic [1:0]  pc_sel,
   output logic        int_out,
   output logic        reg_write,
   output logic        alu_src,
   output logic [2:0]  alu_op,
   output logic [1:0]  wb_sel,
   output logic [31:0] retired,
   output logic [2:0]  state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd5
   } state_t;

   typedef enum logic [2:0] {
      C_NONE = 3'd0,
      C_LW   = 3'd1,
      C_I    = 3'd2,
      C_R    = 3'd3,
      C_S    = 3'd4,
      C_SB   = 3'd5,
      C_UJ   = 3'd6,
      C_ILL  = 3'd7
   } cls_t;

   localparam logic [6:0] OP_LW = 7'b0000011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_SB = 7'b1100011;
   localparam logic [6:0] OP_UJ = 7'b1101111;

   // Returns {class, alu_op}; an R/I encoding with an unsupported funct3 is illegal.
   function automatic logic [5:0] decode_ins(input logic [6:0] op, input logic [2:0] f3,
                                             input logic f7);
      logic [2:0] cls;
      logic [2:0] aop;
      cls = C_ILL;
      aop = 3'b000;
      case (op)
         OP_LW:   begin cls = C_LW; aop = 3'b010; end
         OP_S:    begin cls = C_S;  aop = 3'b010; end
         OP_SB:   begin cls = C_SB; aop = 3'b110; end
         OP_UJ:   begin cls = C_UJ; aop = 3'b000; end
         OP_R, OP_I: begin
            cls = (op == OP_R) ? C_R : C_I;
            case (f3)
               3'b000:  aop = (op == OP_R && f7) ? 3'b110 : 3'b010;
               3'b111:  aop = 3'b000;
               3'b110:  aop = 3'b001;
               3'b010:  aop = 3'b111;
               default: begin cls = C_ILL; aop = 3'b000; end
            endcase
         end
         default: begin cls = C_ILL; aop = 3'b000; end
      endcase
      return {cls, aop};
   endfunction

   state_t      r_state;
   state_t      w_next;
   cls_t        r_cls;
   logic [2:0]  r_alu_op;
   logic [31:0] r_retired;
   logic [5:0]  w_dec;
   cls_t        w_dec_cls;

   logic        w_mem_req;
   logic        w_mem_we;
   logic        w_addr_sel;
   logic        w_ir_load;
   logic        w_pc_write;
   logic [1:0]  w_pc_sel;
   logic        w_int_out;
   logic        w_reg_write;
   logic        w_alu_src;
   logic [2:0]  w_alu_op;
   logic [1:0]  w_wb_sel;

   // Instruction decode of the latched IR fields
   always_comb begin
      w_dec     = decode_ins(opcode, funct3, funct7b5);
      w_dec_cls = cls_t'(w_dec[5:3]);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_FETCH;
      end else begin
         r_state <= w_next;
      end
   end

   // Class and ALU op are captured once in DECODE and held for the rest of the instruction
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cls    <= C_NONE;
         r_alu_op <= 3'b000;
      end else if (r_state == S_DECODE) begin
         r_cls    <= w_dec_cls;
         r_alu_op <= w_dec[2:0];
      end
   end

   // Retired counter: one pc_write per completed instruction, trap excluded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_retired <= 32'd0;
      end else if (w_pc_write && (r_state != S_TRAP)) begin
         r_retired <= r_retired + 32'd1;
      end
   end

   // Next-state and output decode
   always_comb begin
      w_next      = r_state;
      w_mem_req   = 1'b0;
      w_mem_we    = 1'b0;
      w_addr_sel  = 1'b0;
      w_ir_load   = 1'b0;
      w_pc_write  = 1'b0;
      w_pc_sel    = 2'd0;
      w_int_out   = 1'b0;
      w_reg_write = 1'b0;
      w_alu_src   = 1'b0;
      w_alu_op    = 3'b000;
      w_wb_sel    = 2'd0;
      case (r_state)
         S_FETCH: begin
            if (run) begin
               w_mem_req = 1'b1;
               if (mem_ready) begin
                  w_ir_load = 1'b1;
                  w_next    = S_DECODE;
               end else begin
                  w_next    = S_FETCH;
               end
            end else begin
               w_next = S_FETCH;
            end
         end
         S_DECODE: begin
            if (w_dec_cls == C_ILL) begin
               w_next = S_TRAP;
            end else begin
               w_next = S_EXEC;
            end
         end
         S_EXEC: begin
            w_alu_op  = r_alu_op;
            w_alu_src = (r_cls == C_LW) || (r_cls == C_I) || (r_cls == C_S);
            case (r_cls)
               C_SB: begin
                  w_pc_write = 1'b1;
                  w_pc_sel   = zero ? 2'd1 : 2'd0;
                  w_next     = S_FETCH;
               end
               C_LW, C_S: w_next = S_MEM;
               default:   w_next = S_WB;
            endcase
         end
         S_MEM: begin
            w_mem_req  = 1'b1;
            w_addr_sel = 1'b1;
            w_mem_we   = (r_cls == C_S);
            w_alu_op   = r_alu_op;
            w_alu_src  = 1'b1;
            if (mem_ready) begin
               if (r_cls == C_S) begin
                  w_pc_write = 1'b1;
                  w_next     = S_FETCH;
               end else begin
                  w_next     = S_WB;
               end
            end else begin
               w_next = S_MEM;
            end
         end
         S_WB: begin
            w_reg_write = 1'b1;
            w_pc_write  = 1'b1;
            case (r_cls)
               C_LW:    begin w_wb_sel = 2'd1; w_pc_sel = 2'd0; end
               C_UJ:    begin w_wb_sel = 2'd2; w_pc_sel = 2'd2; end
               default: begin w_wb_sel = 2'd0; w_pc_sel = 2'd0; end
            endcase
            w_next = S_FETCH;
         end
         S_TRAP: begin
            w_int_out  = 1'b1;
            w_pc_write = 1'b1;
            w_pc_sel   = 2'd3;
            w_next     = S_FETCH;
         end
         default: w_next = S_FETCH;
      endcase
   end

   // Reset abandons a pending fetch request at once, without waiting for a clock
   assign mem_req   = w_mem_req & rst_n;
   assign ir_load   = w_ir_load & rst_n;
   assign mem_we    = w_mem_we;
   assign addr_sel  = w_addr_sel;
   assign pc_write  = w_pc_write;
   assign pc_sel    = w_pc_sel;
   assign int_out   = w_int_out;
   assign reg_write = w_reg_write;
   assign alu_src   = w_alu_src;
   assign alu_op    = w_alu_op;
   assign wb_sel    = w_wb_sel;
   assign retired   = r_retired;
   assign state     = r_state;

endmodule
